parity_serializer: RTL and testbench

PARITY_SERIALIZER -- requirements
Module: parity_serializer

---
 rtl/parity_serializer.sv | 246 ++++++++++++++++++++++++
 tb/tb_parity_serializer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_serializer.sv
// -----------------------------------------------------------------------------
// parity_serializer
//
// Purpose
//   Takes one payload word plus its even-parity bit from an upstream
//   XOR-parity stage and sends it on a single serial line:
//     start (0) | DATA_W payload bits, LSB first | parity | STOP_BITS stop (1)
//   Every bit lasts CLKS_PER_BIT clock cycles. The line idles high.
//
// Parameters
//   DATA_W        payload width in bits, legal 1..16        (default 9)
//   CLKS_PER_BIT  clock cycles per serial bit, legal 1..255 (default 4)
//   STOP_BITS     number of stop bits, legal 1 or 2         (default 1)
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   in_valid    in   upstream word/parity valid
//   in_ready    out  high only while idle; the word is taken at that edge
//   in_data     in   payload word [DATA_W-1:0]
//   in_parity   in   even-parity bit computed upstream (XOR of in_data)
//   tx          out  serial line, idles high
//   busy        out  high in every state except idle
//   frame_done  out  one-cycle pulse in the last stop cycle of a frame
//   par_err     out  sticky parity-mismatch flag (recheck build only)
//   dbg_state   out  current FSM state: 0 idle, 1 start, 2 data,
//                    3 parity, 4 stop
//
// Build option
//   PARITY_SERIALIZER_RECHECK_EN  when defined, the XOR of in_data is
//   recomputed at the handshake and compared with in_parity; a mismatch sets
//   par_err one edge later and it stays set until rst. When undefined,
//   par_err is tied low and no recheck logic exists.
//
// Handshake
//   A word is accepted at a rising edge where in_valid && in_ready are both
//   high (and rst is low). in_ready depends only on the FSM state, never on
//   in_valid, so upstream may hold in_valid high across frames. Inputs are
//   ignored while in_ready is low.
// -----------------------------------------------------------------------------
module parity_serializer #(
   parameter int DATA_W       = 9,
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_parity,
   output logic              tx,
   output logic              busy,
   output logic              frame_done,
   output logic              par_err,
   output logic [2:0]        dbg_state
);

   // The bit-cycle counter must reach the longest state (the stop field),
   // the index counter must address every payload bit.
   localparam int CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS + 1);
   localparam int IDX_W = $clog2(DATA_W + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              parity_q, parity_d;

   logic hs;
   logic bit_end;

   assign in_ready  = (state_q == IDLE);
   assign hs        = in_valid && in_ready;
   assign bit_end   = (cnt_q == BIT_LAST);
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

   // frame_done marks the final stop cycle; the FSM leaves STOP at the
   // edge that ends this cycle, so the pulse is always exactly one cycle.
   assign frame_done = (state_q == STOP) && (cnt_q == STOP_LAST);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      data_d   = data_q;
      parity_d = parity_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (hs) begin
               // The word is copied once here and held untouched for the
               // whole frame, so upstream may change in_data freely.
               data_d   = in_data;
               parity_d = in_parity;
               state_d  = START;
            end
         end

         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = PARITY;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         STOP: begin
            // The whole stop field is counted in one run rather than bit by
            // bit, which is why the counter is sized for STOP_BITS bits.
            if (cnt_q == STOP_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Serial line: decoded from the registered state only, so it never
   // depends on the upstream inputs.
   // -------------------------------------------------------------------------
   always_comb begin
      tx = 1'b1;
      case (state_q)
         START:   tx = 1'b0;
         DATA:    tx = data_q[idx_q];
         PARITY:  tx = parity_q;   // sent exactly as supplied
         default: tx = 1'b1;
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         parity_q <= parity_d;
      end
   end

   // -------------------------------------------------------------------------
   // Optional parity recheck
   // -------------------------------------------------------------------------
`ifdef PARITY_SERIALIZER_RECHECK_EN
   logic mis_q, mis_d;
   logic par_err_q, par_err_d;

   // mis_q holds the comparison taken at the handshake; it is folded into
   // the sticky flag on the next edge.
   always_comb begin
      mis_d     = hs && ((^in_data) != in_parity);
      par_err_d = par_err_q | mis_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mis_q     <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         mis_q     <= mis_d;
         par_err_q <= par_err_d;
      end
   end

   assign par_err = par_err_q;
`else
   assign par_err = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Embedded properties
   // -------------------------------------------------------------------------
   a_done_then_idle : assert property (@(posedge clk) disable iff (rst)
      frame_done |=> (state_q == IDLE));

   a_cnt_bound : assert property (@(posedge clk)
      cnt_q <= STOP_LAST);

   a_idx_bound : assert property (@(posedge clk)
      idx_q <= IDX_LAST);

   a_word_stable : assert property (@(posedge clk) disable iff (rst)
      (busy && $past(busy)) |-> $stable(data_q));

endmodule

// File: tb/tb_parity_serializer.sv
// -----------------------------------------------------------------------------
// tb_parity_serializer
//   dut_a: DATA_W=9, CLKS_PER_BIT=1, STOP_BITS=1 (frame-level scenarios)
//   dut_b: DATA_W=9, CLKS_PER_BIT=4, STOP_BITS=2 (all-words deserializer run)
//   Cycle n of a frame is the n-th clock period after the handshake edge;
//   outputs are sampled and inputs driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_parity_serializer;

  localparam int DW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          a_valid, a_ready, a_par, a_tx, a_busy, a_done, a_perr;
  logic [DW-1:0] a_data;
  logic [2:0]    a_state;

  logic          b_valid, b_ready, b_par, b_tx, b_busy, b_done, b_perr;
  logic [DW-1:0] b_data;
  logic [2:0]    b_state;

  parity_serializer #(.DATA_W(9), .CLKS_PER_BIT(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_parity(a_par), .tx(a_tx), .busy(a_busy),
    .frame_done(a_done), .par_err(a_perr), .dbg_state(a_state)
  );

  parity_serializer #(.DATA_W(9), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_parity(b_par), .tx(b_tx), .busy(b_busy),
    .frame_done(b_done), .par_err(b_perr), .dbg_state(b_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PARITY_SERIALIZER_RECHECK_EN
  localparam logic EXP_RECHECK = 1'b1;
`else
  localparam logic EXP_RECHECK = 1'b0;
`endif

  // Expected per-cycle behaviour of dut_a: {tx, in_ready, frame_done}
  logic [2:0]    exp_q[$];
  // Words handed to dut_b, popped by the bench deserializer
  logic [DW-1:0] word_q[$];

  // ---------------------------------------------------------------- model
  // Builds the line picture of one frame from the framing rules.
  function automatic void push_frame(input logic [DW-1:0] d, input logic p,
                                     input int cpb, input int stop);
    logic bits[$];
    int   total;
    int   n;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    bits.push_back(p);
    for (int s = 0; s < stop; s++) bits.push_back(1'b1);
    total = bits.size() * cpb;
    n = 0;
    foreach (bits[k]) begin
      for (int c = 0; c < cpb; c++) begin
        n++;
        exp_q.push_back({bits[k], 1'b0, (n == total)});
      end
    end
  endfunction

  function automatic void push_idle();
    exp_q.push_back(3'b110);
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for in_ready, hands over one word, returns in cycle 1.
  task automatic start_a(input logic [DW-1:0] d, input logic p);
    int t = 0;
    while (a_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_a timeout: in_ready=%b required 1", a_ready);
    end
    a_valid = 1'b1;
    a_data  = d;
    a_par   = p;
    @(negedge clk);
    a_valid = 1'b0;
    a_data  = DW'($urandom);
    a_par   = 1'($urandom);
  endtask

  task automatic start_b(input logic [DW-1:0] d, input logic p);
    int t = 0;
    while (b_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_b timeout: in_ready=%b required 1", b_ready);
    end
    b_valid = 1'b1;
    b_data  = d;
    b_par   = p;
    @(negedge clk);
    b_valid = 1'b0;
    b_data  = DW'($urandom);
    b_par   = 1'($urandom);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({a_tx, a_busy, a_done, a_perr, a_ready} !== 5'b10001) begin
        n_fail++;
        $display("FAIL reset_a k=%0d: tx,busy,done,perr,rdy=%b required 10001", k,
                 {a_tx, a_busy, a_done, a_perr, a_ready});
      end
      n_checks++;
      if ({b_tx, b_busy, b_done, b_perr, b_ready} !== 5'b10001) begin
        n_fail++;
        $display("FAIL reset_b k=%0d: tx,busy,done,perr,rdy=%b required 10001", k,
                 {b_tx, b_busy, b_done, b_perr, b_ready});
      end
      n_checks++;
      if (a_state !== 3'd0 || b_state !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_state: a=%0d b=%0d required 0", a_state, b_state);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_frame_1a5();
    logic [11:0] got = '0;
    logic [2:0]  e;
    int          cyc = 1;
    exp_q.delete();
    push_frame(9'h1A5, 1'b1, 1, 1);
    push_idle();
    start_a(9'h1A5, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (cyc <= 12) got = {got[10:0], a_tx};
      n_checks++;
      if ({a_tx, a_ready, a_done} !== e || a_busy !== ~e[1]) begin
        n_fail++;
        $display("FAIL frame_1a5 cyc=%0d: tx,rdy,done,busy=%b%b%b%b required %b%b%b%b",
                 cyc, a_tx, a_ready, a_done, a_busy, e[2], e[1], e[0], ~e[1]);
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (got !== 12'b0101_0010_1111) begin
      n_fail++;
      $display("FAIL frame_1a5_line: tx=%b required 010100101111", got);
    end
  endtask

  task automatic test_random_frames();
    logic [DW-1:0] d;
    logic [2:0]    e;
    int            cyc;
    for (int f = 0; f < 8; f++) begin
      d = DW'($urandom_range(0, 511));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      exp_q.delete();
      push_frame(d, ^d, 1, 1);
      push_idle();
      start_a(d, ^d);
      cyc = 1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({a_tx, a_ready, a_done} !== e || a_busy !== ~e[1] || a_perr !== 1'b0) begin
          n_fail++;
          $display("FAIL random_frame d=%h cyc=%0d: tx,rdy,done,busy,perr=%b%b%b%b%b required %b%b%b%b0",
                   d, cyc, a_tx, a_ready, a_done, a_busy, a_perr, e[2], e[1], e[0], ~e[1]);
        end
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    int         cyc = 1;
    exp_q.delete();
    push_frame(9'h0FF, 1'b0, 1, 1);
    push_idle();
    push_frame(9'h100, 1'b1, 1, 1);
    push_idle();
    a_valid = 1'b1;
    a_data  = 9'h0FF;
    a_par   = 1'b0;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({a_tx, a_ready, a_done} !== e || a_busy !== ~e[1]) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d: tx,rdy,done,busy=%b%b%b%b required %b%b%b%b",
                 cyc, a_tx, a_ready, a_done, a_busy, e[2], e[1], e[0], ~e[1]);
      end
      if (cyc <= 12) begin
        a_data = DW'($urandom);
        a_par  = 1'($urandom);
      end else if (cyc == 13) begin
        a_data = 9'h100;
        a_par  = 1'b1;
      end else if (cyc == 14) begin
        a_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    int         cyc = 1;
    exp_q.delete();
    push_frame(9'h1A5, 1'b1, 1, 1);
    start_a(9'h1A5, 1'b1);
    for (cyc = 1; cyc <= 5; cyc++) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({a_tx, a_ready, a_done} !== e) begin
        n_fail++;
        $display("FAIL reset_mid_pre cyc=%0d: tx,rdy,done=%b%b%b required %b",
                 cyc, a_tx, a_ready, a_done, e);
      end
      if (cyc == 5) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    for (int k = 6; k <= 7; k++) begin
      n_checks++;
      if ({a_tx, a_busy, a_ready, a_done} !== 4'b1010) begin
        n_fail++;
        $display("FAIL reset_mid cyc=%0d: tx,busy,rdy,done=%b required 1010",
                 k, {a_tx, a_busy, a_ready, a_done});
      end
      @(negedge clk);
    end
    exp_q.delete();
    push_frame(9'h000, 1'b0, 1, 1);
    push_idle();
    start_a(9'h000, 1'b0);
    cyc = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({a_tx, a_ready, a_done} !== e || a_busy !== ~e[1]) begin
        n_fail++;
        $display("FAIL reset_mid_next cyc=%0d: tx,rdy,done,busy=%b%b%b%b required %b%b%b%b",
                 cyc, a_tx, a_ready, a_done, a_busy, e[2], e[1], e[0], ~e[1]);
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_rst_priority();
    a_valid = 1'b1;
    a_data  = 9'h1A5;
    a_par   = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    a_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({a_tx, a_busy, a_ready} !== 3'b101) begin
        n_fail++;
        $display("FAIL rst_priority k=%0d: tx,busy,rdy=%b required 101",
                 k, {a_tx, a_busy, a_ready});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_all_words();
    logic          samp [52];
    logic [DW-1:0] got_d;
    logic [DW-1:0] exp_d;
    logic          got_p;
    int            shape_bad;
    int            perr_bad;
    for (int w = 0; w < 512; w++) begin
      word_q.push_back(DW'(w));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_b(DW'(w), ^(DW'(w)));
      shape_bad = 0;
      perr_bad  = 0;
      for (int c = 0; c < 52; c++) begin
        samp[c] = b_tx;
        if (b_busy !== 1'b1 || b_ready !== 1'b0 || b_done !== (c == 51)) shape_bad++;
        if (b_perr !== 1'b0) perr_bad++;
        @(negedge clk);
      end
      // Cycle 53: the frame must be over.
      if (b_busy !== 1'b0 || b_ready !== 1'b1 || b_tx !== 1'b1) shape_bad++;
      // Deserialize: every bit cell is 4 samples wide and must be flat.
      for (int k = 0; k < 13; k++)
        for (int s = 1; s < 4; s++)
          if (samp[k*4+s] !== samp[k*4]) shape_bad++;
      for (int i = 0; i < DW; i++) got_d[i] = samp[(1 + i) * 4 + 2];
      got_p = samp[10*4 + 2];
      exp_d = word_q.pop_front();
      n_checks++;
      if (got_d !== exp_d || got_p !== ^exp_d) begin
        n_fail++;
        $display("FAIL all_words data: got %h/%b required %h/%b", got_d, got_p, exp_d, ^exp_d);
      end
      n_checks++;
      if (samp[2] !== 1'b0 || samp[46] !== 1'b1 || samp[50] !== 1'b1) begin
        n_fail++;
        $display("FAIL all_words framing w=%h: start,stop1,stop2=%b%b%b required 011",
                 exp_d, samp[2], samp[46], samp[50]);
      end
      n_checks++;
      if (shape_bad !== 0) begin
        n_fail++;
        $display("FAIL all_words shape w=%h: %0d bad cycles required 0", exp_d, shape_bad);
      end
      n_checks++;
      if (perr_bad !== 0) begin
        n_fail++;
        $display("FAIL all_words par_err w=%h: %0d cycles high required 0", exp_d, perr_bad);
      end
    end
  endtask

  task automatic test_par_err();
    logic [2:0] e;
    int         cyc;
    // Bad parity frame followed by a good one; the flag must persist.
    for (int f = 0; f < 2; f++) begin
      exp_q.delete();
      if (f == 0) begin
        push_frame(9'h000, 1'b1, 1, 1);
        start_a(9'h000, 1'b1);
      end else begin
        push_frame(9'h0FF, 1'b0, 1, 1);
        start_a(9'h0FF, 1'b0);
      end
      push_idle();
      cyc = 1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({a_tx, a_ready, a_done} !== e) begin
          n_fail++;
          $display("FAIL par_err_frame f=%0d cyc=%0d: tx,rdy,done=%b%b%b required %b",
                   f, cyc, a_tx, a_ready, a_done, e);
        end
        if (f == 1 || cyc >= 2) begin
          n_checks++;
          if (a_perr !== EXP_RECHECK) begin
            n_fail++;
            $display("FAIL par_err f=%0d cyc=%0d: par_err=%b required %b",
                     f, cyc, a_perr, EXP_RECHECK);
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    do_reset();
    n_checks++;
    if (a_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL par_err_cleared: par_err=%b required 0", a_perr);
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    rst     = 1'b1;
    a_valid = 1'b0;
    a_data  = '0;
    a_par   = 1'b0;
    b_valid = 1'b0;
    b_data  = '0;
    b_par   = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame_1a5();
    test_random_frames();
    test_back_to_back();
    test_reset_mid();
    test_rst_priority();
    test_all_words();
    test_par_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
